reglk_arbiter: RTL and testbench

- Sequences and shares the single word-addressed data memory port between two requesters: m0 (core) and m1 (debug/JTAG).
- Owns a bank of sticky per-word write-lock bits.
- A write to a locked word is blocked and reported as an error.
- Lock bits clear only on the global reset rst_ni. There is no block-local reset and no unlock input, so locks cannot be dropped at runtime.

---
 rtl/reglk_arbiter.sv | 159 +++++++++++++++
 tb/tb_reglk_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reglk_arbiter.sv
// Two-requester round-robin arbiter for a single data memory port, with sticky per-word write locks.
// Lock registers are memory-mapped; a write ORs new bits in, and only rst_ni clears them.
module reglk_arbiter #(
  parameter int          NUM_LOCK_WORDS = 6,
  parameter int          MEM_WORDS      = 200,
  parameter logic [31:0] LOCK_BASE_ADDR = 32'h0000_0400
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         m0_req_i,
  input  logic                         m0_we_i,
  input  logic [31:0]                  m0_addr_i,
  input  logic [31:0]                  m0_wdata_i,
  output logic                         m0_gnt_o,
  output logic                         m0_rvalid_o,
  output logic [31:0]                  m0_rdata_o,
  output logic                         m0_err_o,
  input  logic                         m1_req_i,
  input  logic                         m1_we_i,
  input  logic [31:0]                  m1_addr_i,
  input  logic [31:0]                  m1_wdata_i,
  output logic                         m1_gnt_o,
  output logic                         m1_rvalid_o,
  output logic [31:0]                  m1_rdata_o,
  output logic                         m1_err_o,
  output logic                         mem_we_o,
  output logic [31:0]                  mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [2:0]                   mem_width_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [NUM_LOCK_WORDS*32-1:0] reglk_o
);

  // state  | meaning
  // IDLE   | waiting for a request; grant is combinational here
  // ACCESS | latched request classified; memory or lock register accessed
  // RESP   | rvalid pulse to the latched requester, RR pointer flips
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int          LOCK_BITS      = NUM_LOCK_WORDS * 32;
  localparam logic [29:0] LOCK_BASE_WORD = LOCK_BASE_ADDR[31:2];

  logic [1:0]           state;
  logic                 rr_ptr;
  logic                 lat_id;
  logic                 lat_we;
  logic [29:0]          lat_word;
  logic [31:0]          lat_wdata;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic [LOCK_BITS-1:0] reglk;

  logic        idle;
  logic        access;
  logic        resp;
  logic        pick_m1;
  logic        in_lock;
  logic        out_of_range;
  logic [29:0] lk_idx;
  logic        lock_bit;
  logic [31:0] lock_rd;
  logic        acc_err;
  logic        unused_addr_bits;

  assign idle   = (state == S_IDLE);
  assign access = (state == S_ACCESS);
  assign resp   = (state == S_RESP);

  // m1 wins when it is alone or when both ask and the pointer favours it
  assign pick_m1  = m1_req_i & (~m0_req_i | rr_ptr);
  assign m0_gnt_o = idle & m0_req_i & ~pick_m1;
  assign m1_gnt_o = idle & pick_m1;

  assign unused_addr_bits = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  assign in_lock      = (lat_word >= LOCK_BASE_WORD) &&
                        (lat_word <  LOCK_BASE_WORD + 30'(NUM_LOCK_WORDS));
  assign lk_idx       = lat_word - LOCK_BASE_WORD;
  assign out_of_range = (lat_word >= 30'(MEM_WORDS));

  // words beyond the lock bank have no lock bit and are never locked
  always_comb begin
    lock_bit = 1'b0;
    for (int k = 0; k < LOCK_BITS; k++) begin
      if (lat_word == 30'(k)) lock_bit = reglk[k];
    end
  end

  always_comb begin
    lock_rd = '0;
    for (int j = 0; j < NUM_LOCK_WORDS; j++) begin
      if (lk_idx == 30'(j)) lock_rd = reglk[j*32 +: 32];
    end
  end

  assign acc_err = !in_lock && (out_of_range || (lat_we && lock_bit));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      reglk      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_req_i || m1_req_i) begin
            lat_id    <= pick_m1;
            lat_we    <= pick_m1 ? m1_we_i : m0_we_i;
            lat_word  <= pick_m1 ? m1_addr_i[31:2] : m0_addr_i[31:2];
            lat_wdata <= pick_m1 ? m1_wdata_i : m0_wdata_i;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          resp_err <= acc_err;
          if (in_lock) begin
            resp_rdata <= lat_we ? 32'h0 : lock_rd;
            for (int j = 0; j < NUM_LOCK_WORDS; j++) begin
              if (lat_we && lk_idx == 30'(j))
                reglk[j*32 +: 32] <= reglk[j*32 +: 32] | lat_wdata;
            end
          end else if (acc_err || lat_we) begin
            resp_rdata <= 32'h0;
          end else begin
            resp_rdata <= mem_rdata_i;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          rr_ptr <= ~lat_id;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m0_rvalid_o = resp && !lat_id;
  assign m1_rvalid_o = resp &&  lat_id;
  assign m0_rdata_o  = m0_rvalid_o ? resp_rdata : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? resp_rdata : 32'h0;
  assign m0_err_o    = m0_rvalid_o && resp_err;
  assign m1_err_o    = m1_rvalid_o && resp_err;

  assign mem_we_o    = access && lat_we && !in_lock && !acc_err;
  assign mem_addr_o  = access ? {lat_word, 2'b00} : 32'h0;
  assign mem_wdata_o = access ? lat_wdata : 32'h0;
  assign mem_width_o = 3'b010;
  assign reglk_o     = reglk;

endmodule

// File: tb/tb_reglk_arbiter.sv
// Directed bench for reglk_arbiter: vector table of single transactions plus
// hand-written arbitration and mid-access reset sequences against a memory stub.
module tb_reglk_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0]  m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic         m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0]  m0_rdata_o, m1_rdata_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]   mem_width_o;
  logic [191:0] reglk_o;

  reglk_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_width_o(mem_width_o), .mem_rdata_i(mem_rdata_i), .reglk_o(reglk_o)
  );

  always #5 clk_i = ~clk_i;

  // memory stub: 200 words, combinational read, write on posedge
  logic [31:0] tbmem [200];
  initial for (int i = 0; i < 200; i++) tbmem[i] = 32'h0;
  always_comb begin
    mem_rdata_i = 32'h0;
    if (mem_addr_o[31:2] < 30'd200) mem_rdata_i = tbmem[mem_addr_o[9:2]];
  end
  always @(posedge clk_i) if (mem_we_o && mem_addr_o[31:2] < 30'd200) tbmem[mem_addr_o[9:2]] <= mem_wdata_o;

  typedef struct {
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    bit          memwe;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   last_id = 1'b0;
  vec_t vecs [18];
  logic [31:0] exp_lk [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit id, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (!id) begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata;
    end
  endtask

  function automatic logic gnt_of(input bit id);
    return id ? m1_gnt_o : m0_gnt_o;
  endfunction

  task automatic check_locks(input string tag);
    for (int j = 0; j < 6; j++)
      chk($sformatf("%s_reglk%0d", tag, j), reglk_o[j*32 +: 32], exp_lk[j]);
  endtask

  task automatic txn(input string tag, input vec_t v);
    int n;
    @(negedge clk_i);
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    #1;
    n = 0;
    while (!gnt_of(v.id) && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    chk({tag, "_gnt"}, {31'h0, gnt_of(v.id)}, 32'h1);
    if (!gnt_of(v.id)) begin
      drive(v.id, 1'b0, 1'b0, 32'h0, 32'h0);
      return;
    end
    chk({tag, "_other_gnt"}, {31'h0, gnt_of(!v.id)}, 32'h0);
    @(negedge clk_i);
    drive(v.id, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk({tag, "_mem_we"}, {31'h0, mem_we_o}, {31'h0, v.memwe});
    if (v.memwe) begin
      chk({tag, "_mem_addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
      chk({tag, "_mem_wdata"}, mem_wdata_o, v.wdata);
    end
    chk({tag, "_early_rvalid"}, {31'h0, m0_rvalid_o | m1_rvalid_o}, 32'h0);
    @(negedge clk_i); #1;
    chk({tag, "_rvalid"}, {31'h0, v.id ? m1_rvalid_o : m0_rvalid_o}, 32'h1);
    chk({tag, "_other_rvalid"}, {31'h0, v.id ? m0_rvalid_o : m1_rvalid_o}, 32'h0);
    chk({tag, "_rdata"}, v.id ? m1_rdata_o : m0_rdata_o, v.rdata);
    chk({tag, "_err"}, {31'h0, v.id ? m1_err_o : m0_err_o}, {31'h0, v.err});
    chk({tag, "_resp_mem_we"}, {31'h0, mem_we_o}, 32'h0);
    last_id = v.id;
  endtask

  initial begin
    int   gnt_cyc [8];
    bit   gnt_id [8];
    int   ng, rv0, rv1, both, bad;
    bit   first;
    vec_t v;

    //              id    we    addr           wdata          rdata          err   memwe
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0400, 32'h0000_0010, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0400, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0010, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0320, 32'h1111_1111, 32'h0,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0320, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0414, 32'h8000_0001, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0414, 32'h0,         32'h8000_0001, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0280, 32'h2222_2222, 32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0284, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0284, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_031C, 32'h0000_0077, 32'h0,         1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0418, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_0280, 32'h0,         32'h0,         1'b0, 1'b0};

    for (int j = 0; j < 6; j++) exp_lk[j] = 32'h0;

    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_gnt", {30'h0, m0_gnt_o, m1_gnt_o}, 32'h0);
    chk("rst_rvalid", {30'h0, m0_rvalid_o, m1_rvalid_o}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_width", {29'h0, mem_width_o}, 32'h2);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    check_locks("rst");

    for (int i = 0; i < 18; i++) begin
      txn($sformatf("v%0d", i), vecs[i]);
      if (i == 2) begin
        exp_lk[0] = 32'h0000_0010;
        check_locks("after_lock");
      end
      if (i == 5) check_locks("sticky");
      if (i == 9) exp_lk[5] = 32'h8000_0001;
    end
    check_locks("table_end");
    chk("mem_w161", tbmem[161], 32'hA5A5_A5A5);
    chk("mem_w199", tbmem[199], 32'h0000_0077);

    // both requesters held: grants alternate, starting with the side not last served
    @(negedge clk_i);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0284, 32'h0);
    ng = 0; rv0 = 0; rv1 = 0; both = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (m0_gnt_o && m1_gnt_o) both++;
      if ((m0_gnt_o || m1_gnt_o) && ng < 8) begin
        gnt_cyc[ng] = c; gnt_id[ng] = m1_gnt_o; ng++;
      end
      if (m0_rvalid_o) begin
        rv0++;
        chk("arb_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
      end
      if (m1_rvalid_o) begin
        rv1++;
        chk("arb_m1_rdata", m1_rdata_o, 32'hA5A5_A5A5);
      end
    end
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("arb_num_gnt", ng, 4);
    chk("arb_both_gnt", both, 0);
    chk("arb_rv0", rv0, 2);
    chk("arb_rv1", rv1, 2);
    first = !last_id;
    for (int g = 0; g < 4 && g < ng; g++) begin
      chk($sformatf("arb_gnt%0d_id", g), {31'h0, gnt_id[g]}, {31'h0, first ^ g[0]});
      chk($sformatf("arb_gnt%0d_cyc", g), gnt_cyc[g], 3 * g);
    end

    // reset during ACCESS of a write: no write lands, no response, locks cleared
    @(negedge clk_i);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0014, 32'h5555_5555);
    #1;
    chk("rst_seq_gnt", {31'h0, m0_gnt_o}, 32'h1);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_seq_access_we", {31'h0, mem_we_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rst_seq_we_off", {31'h0, mem_we_o}, 32'h0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i); #1;
      if (m0_rvalid_o || m1_rvalid_o || mem_we_o) bad++;
    end
    chk("rst_seq_quiet", bad, 0);
    chk("rst_seq_mem_w5", tbmem[5], 32'h0);
    for (int j = 0; j < 6; j++) exp_lk[j] = 32'h0;
    check_locks("rst_seq");
    chk("rst_seq_width", {29'h0, mem_width_o}, 32'h2);
    @(negedge clk_i);
    rst_ni = 1'b1;

    v = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    txn("post_rst_rd", v);
    v = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b1};
    txn("post_rst_wr", v);
    v = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b0};
    txn("post_rst_rd2", v);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
